// File: rtl/router_mode_sequencer.sv
// Run-time mode controller for one router tile: drains outstanding flits, holds the
// tile in reset while MODE changes, then releases it and acknowledges the request.
module router_mode_sequencer #(
  parameter int         NUM_PORTS     = 5,
  parameter int         CREDITS       = 8,
  parameter int         RESET_CYCLES  = 4,
  parameter int         DRAIN_TIMEOUT = 1024,
  parameter logic [1:0] MODE_RESET    = 2'b00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_req,
  input  logic [1:0]           cfg_mode,
  output logic                 cfg_ack,
  output logic                 cfg_busy,
  output logic                 err_illegal,
  output logic                 err_timeout,
  output logic                 err_credit,
  input  logic [NUM_PORTS-1:0] flit_sent,
  input  logic [NUM_PORTS-1:0] credit_ret,
  output logic                 inject_block,
  output logic                 router_reset,
  output logic [1:0]           router_mode
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RST, S_RELEASE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt [NUM_PORTS];
  logic [TW-1:0]  r_to_cnt;
  logic [RW-1:0]  r_rst_cnt;
  logic [1:0]     r_pending;
  logic           r_cfg_ack, r_cfg_busy, r_err_illegal, r_err_timeout, r_err_credit;
  logic           r_inject_block, r_router_reset;
  logic [1:0]     r_router_mode;
  logic           w_drained, w_cnt_err;
  logic           w_ack_set, w_ill_set, w_to_set, w_latch;

  // Over/underflow detection and the drained flag both look at registered counts.
  always_comb begin
    w_drained = 1'b1;
    w_cnt_err = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_cnt[p] != '0) w_drained = 1'b0;
      if (r_state != S_RST) begin
        if (flit_sent[p] && !credit_ret[p] && r_cnt[p] == CW'(CREDITS)) w_cnt_err = 1'b1;
        if (credit_ret[p] && !flit_sent[p] && r_cnt[p] == '0)           w_cnt_err = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_next    = r_state;
    w_ack_set = 1'b0;
    w_ill_set = 1'b0;
    w_to_set  = 1'b0;
    w_latch   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_req) begin
          if (cfg_mode == 2'b11)              w_ill_set = 1'b1;
          else if (cfg_mode == r_router_mode) w_ack_set = 1'b1;
          else begin
            w_latch = 1'b1;
            w_next  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_drained) w_next = S_RST;
        else if (r_to_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
          w_next   = S_RST;
          w_to_set = 1'b1;
        end
      end
      S_RST: begin
        if (r_rst_cnt == RW'(RESET_CYCLES - 1)) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        w_next    = S_IDLE;
        w_ack_set = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      r_state        <= S_IDLE;
      r_to_cnt       <= '0;
      r_rst_cnt      <= '0;
      r_pending      <= MODE_RESET;
      r_cfg_ack      <= 1'b0;
      r_cfg_busy     <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_credit   <= 1'b0;
      r_inject_block <= 1'b0;
      r_router_reset <= 1'b0;
      r_router_mode  <= MODE_RESET;
      // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is cheap
      // and required for a clean drained flag after reset.
      for (int p = 0; p < NUM_PORTS; p++) r_cnt[p] <= '0;
    end else begin
      r_state        <= w_next;
      r_cfg_ack      <= w_ack_set;
      r_err_illegal  <= w_ill_set;
      r_err_timeout  <= w_to_set;
      r_err_credit   <= r_err_credit | w_cnt_err;
      r_to_cnt       <= (r_state == S_DRAIN) ? r_to_cnt + 1'b1 : '0;
      r_rst_cnt      <= (r_state == S_RST) ? r_rst_cnt + 1'b1 : '0;
      r_router_reset <= (w_next == S_RST);
      r_inject_block <= (w_next != S_IDLE);
      r_cfg_busy     <= (w_next != S_IDLE);
      if (w_latch) r_pending <= cfg_mode;
      if (r_state == S_DRAIN && w_next == S_RST) r_router_mode <= r_pending;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_state == S_RST) r_cnt[p] <= '0;
        else if (flit_sent[p] && !credit_ret[p] && r_cnt[p] != CW'(CREDITS))
          r_cnt[p] <= r_cnt[p] + 1'b1;
        else if (credit_ret[p] && !flit_sent[p] && r_cnt[p] != '0)
          r_cnt[p] <= r_cnt[p] - 1'b1;
      end
    end
  end

  assign cfg_ack      = r_cfg_ack;
  assign cfg_busy     = r_cfg_busy;
  assign err_illegal  = r_err_illegal;
  assign err_timeout  = r_err_timeout;
  assign err_credit   = r_err_credit;
  assign inject_block = r_inject_block;
  assign router_reset = r_router_reset;
  assign router_mode  = r_router_mode;

endmodule
